// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM state encoding
// and the half-width helper used to size the time-multiplexed core.
package vedic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int half_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/vedic_mul_half.sv
// Combinational H x H unsigned Urdhva-Tiryagbhyam multiplier: each product
// column k sums its vertical/crosswise bit products, then columns are weighted.
module vedic_mul_half #(
  parameter int H = 16
) (
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-1:0] p_o
);

  localparam int CW = $clog2(H + 1);
  localparam int PW = 2 * H;

  logic [CW-1:0] col;

  // NOTE: combinational logic uses blocking assignments, and every variable is
  // given a value at the top of the block so no latch can be inferred.
  always_comb begin
    p_o = '0;
    col = '0;
    for (int k = 0; k < 2 * H - 1; k++) begin
      col = '0;
      for (int i = 0; i < H; i++) begin
        if ((k - i >= 0) && (k - i < H)) begin
          col = col + CW'(a_i[i] & b_i[k - i]);
        end
      end
      p_o = p_o + (PW'(col) << k);
    end
  end

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential WIDTH x WIDTH multiplier: one half-width Vedic core is reused over
// four cycles (one per quadrant) with valid/ready handshakes on both sides.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  localparam int H  = half_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_q, neg_d;
  logic [W2-1:0]    acc_q, acc_d, c_q, c_d;
  logic             out_valid_q, out_valid_d;

  logic [H-1:0]     op_a, op_b;
  logic [WIDTH-1:0] part;
  logic [W2-1:0]    addend, acc_sum;
  logic             accept;

  // Signed operands are reduced to magnitudes; -2^(W-1) maps onto itself,
  // which is exactly its magnitude read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ST_P0) || (state_q == ST_P1) ||
                     (state_q == ST_P2) || (state_q == ST_P3);
  assign out_valid = out_valid_q;
  assign c         = c_q;

  always_comb begin
    op_a = a_q[H-1:0];
    op_b = b_q[H-1:0];
    case (state_q)
      ST_P1:   op_a = a_q[WIDTH-1:H];
      ST_P2:   op_b = b_q[WIDTH-1:H];
      ST_P3: begin
        op_a = a_q[WIDTH-1:H];
        op_b = b_q[WIDTH-1:H];
      end
      default: ;
    endcase
  end

  vedic_mul_half #(.H(H)) u_core (
    .a_i(op_a),
    .b_i(op_b),
    .p_o(part)
  );

  always_comb begin
    addend = '0;
    case (state_q)
      ST_P0:        addend = W2'(part);
      ST_P1, ST_P2: addend = W2'(part) << H;
      ST_P3:        addend = W2'(part) << (2 * H);
      default:      ;
    endcase
  end

  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_P0: begin acc_d = acc_sum; state_d = ST_P1; end
      ST_P1: begin acc_d = acc_sum; state_d = ST_P2; end
      ST_P2: begin acc_d = acc_sum; state_d = ST_P3; end
      ST_P3: begin
        acc_d       = acc_sum;
        c_d         = neg_q ? -acc_sum : acc_sum;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase
    // A new transfer overrides IDLE and the completing DONE cycle alike.
    if (accept) begin
      a_d     = mag(a, sgn);
      b_d     = mag(b, sgn);
      neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d   = '0;
      state_d = ST_P0;
    end
  end

  // NOTE: state registers use non-blocking assignments; all of them, operand
  // registers included, are reset so nothing stale survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Directed bench for vedic_mul_seq (WIDTH = 32): vector table plus hand-written
// back-pressure, ignored-handshake and mid-operation reset sequences.
module tb_vedic_mul_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           sgn = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[8];

  vedic_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then presents operands for exactly one edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_ready_timeout", 1'b0, 1'b1);
    a = av; b = bv; sgn = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges (acceptance edge = 1) until out_valid is seen, and the
  // number of sampled cycles in which busy was high on the way.
  task automatic wait_result(input int start, output int edges, output int busy_cnt);
    edges = start;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("take_out_valid_drops", out_valid, 1'b0);
  endtask

  initial begin
    int edges, bcnt;

    vecs[0] = '{32'd13,        32'd37,       1'b0, 64'd481,                   "u_13x37"};
    vecs[1] = '{32'd0,         32'd14,       1'b0, 64'd0,                     "u_0x14"};
    vecs[2] = '{32'd16777210,  32'd1048531,  1'b0, 64'd17591424778510,        "u_large"};
    vecs[3] = '{32'hFFFFFFFD,  32'd7,        1'b1, 64'hFFFFFFFF_FFFFFFEB,     "s_m3x7"};
    vecs[4] = '{32'hFFFFFFFD,  32'd7,        1'b0, 64'h00000006_FFFFFFEB,     "u_fffffffdx7"};
    vecs[5] = '{32'h80000000,  32'h80000000, 1'b1, 64'h40000000_00000000,     "s_minxmin"};
    vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001,     "u_maxxmax"};
    vecs[7] = '{32'h80000000,  32'd1,        1'b1, 64'hFFFFFFFF_80000000,     "s_minx1"};

    // Reset state, asserted without any clock edge yet
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_c", c, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_result(1, edges, bcnt);
      check({vecs[i].name, "_latency_edges"}, 64'(edges), 64'd5);
      check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd4);
      check({vecs[i].name, "_c"}, c, vecs[i].exp);
      take();
    end

    // Back-pressure: result holds for 3 cycles, then a new issue rides the transfer
    issue(32'hFFFFFFFD, 32'd7, 1'b1);
    wait_result(1, edges, bcnt);
    check("bp_first_c", c, 64'hFFFFFFFF_FFFFFFEB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_out_valid", out_valid, 1'b1);
      check("bp_hold_c", c, 64'hFFFFFFFF_FFFFFFEB);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'd8; b = 32'd9; sgn = 1'b0; in_valid = 1'b1;
    #1 check("bp_in_ready_with_out_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp_straight_to_p0_busy", busy, 1'b1);
    check("bp_out_valid_dropped", out_valid, 1'b0);
    check("bp_c_unchanged_until_p3", c, 64'hFFFFFFFF_FFFFFFEB);
    wait_result(1, edges, bcnt);
    check("bp_second_latency_edges", 64'(edges), 64'd5);
    check("bp_second_c", c, 64'd72);
    take();

    // Handshake ignore: in_valid pulsed while computing must not be accepted
    issue(32'd1000, 32'd1000, 1'b0);
    @(negedge clk);
    check("ign_in_ready_busy", in_ready, 1'b0);
    a = 32'd67; b = 32'd49; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ign_in_ready_busy2", in_ready, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(3, edges, bcnt);
    check("ign_latency_edges", 64'(edges), 64'd5);
    check("ign_inflight_c", c, 64'd1000000);
    take();
    @(negedge clk);
    check("ign_no_extra_op_busy", busy, 1'b0);
    check("ign_no_extra_op_valid", out_valid, 1'b0);
    issue(32'd119, 32'd8, 1'b0);
    wait_result(1, edges, bcnt);
    check("ign_followup_c", c, 64'd952);
    take();

    // Reset during P2 aborts asynchronously
    issue(32'd500, 32'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_c", c, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_stale_valid", out_valid, 1'b0);
    end
    issue(32'd13, 32'd37, 1'b0);
    wait_result(1, edges, bcnt);
    check("mid_rst_after_latency", 64'(edges), 64'd5);
    check("mid_rst_after_c", c, 64'd481);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
